// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline hazard / stall / flush controller.
// RUN / MWAIT / HALT sequencing with stall and flush accounting.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs_num,
  input  logic [2:0]  id_rt_num,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [2:0]  idex_dst,
  input  logic [2:0]  exmem_dst,
  input  logic [2:0]  memwb_dst,
  input  logic        idex_wr,
  input  logic        exmem_wr,
  input  logic        memwb_wr,
  input  logic        ex_redirect,
  input  logic        imem_stall,
  input  logic        mem_stall,
  input  logic        halt_in,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        memwb_en,
  output logic        halted,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      r_state;
  logic        r_halted;
  logic        r_timeout;
  logic [5:0]  r_wcnt;
  logic [15:0] r_stall;
  logic [7:0]  r_flush;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_raw;
  logic w_freeze;
  logic w_redir;
  logic w_hzd;
  logic w_imem;
  logic w_run;

  // source operand collides with a pending write in EX, MEM or WB
  always_comb begin
    w_rs_hit = id_rs_used &
      ((idex_wr  & (id_rs_num == idex_dst))  |
       (exmem_wr & (id_rs_num == exmem_dst)) |
       (memwb_wr & (id_rs_num == memwb_dst)));
    w_rt_hit = id_rt_used &
      ((idex_wr  & (id_rt_num == idex_dst))  |
       (exmem_wr & (id_rt_num == exmem_dst)) |
       (memwb_wr & (id_rt_num == memwb_dst)));
    w_raw = w_rs_hit | w_rt_hit;
  end

  // one-hot action select, highest priority event wins; reset looks like idle RUN
  always_comb begin
    w_freeze = rst & ((r_state == HALT) | halt_in | mem_stall);
    w_redir  = rst & ~w_freeze & ex_redirect;
    w_hzd    = rst & ~w_freeze & ~ex_redirect & w_raw;
    w_imem   = rst & ~w_freeze & ~ex_redirect & ~w_raw & imem_stall;
    w_run    = ~(w_freeze | w_redir | w_hzd | w_imem);
  end

  // stage enables and flushes for the selected action
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    unique case (1'b1)
      w_freeze: begin
      end
      w_redir: begin
        pc_en      = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end
      w_hzd: begin
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end
      w_imem: begin
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end
      w_run: begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // FSM, wait watchdog and saturating statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
      r_wcnt    <= 6'd0;
      r_stall   <= 16'd0;
      r_flush   <= 8'd0;
    end else begin
      if ((r_state != HALT) && !pc_en && (r_stall != 16'hFFFF))
        r_stall <= r_stall + 16'd1;
      if (w_redir && (r_flush != 8'hFF))
        r_flush <= r_flush + 8'd1;
      if ((r_state == MWAIT) && mem_stall) begin
        if (r_wcnt != 6'd63)
          r_wcnt <= r_wcnt + 6'd1;
        if (r_wcnt >= 6'd62)
          r_timeout <= 1'b1;
      end else begin
        r_wcnt <= 6'd0;
      end
      case (r_state)
        RUN, MWAIT: begin
          if (halt_in) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (mem_stall) begin
            r_state <= MWAIT;
          end else begin
            r_state <= RUN;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign halted       = r_halted;
  assign mem_timeout  = r_timeout;
  assign stall_cycles = r_stall;
  assign flush_count  = r_flush;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: random and directed checks of pipe_ctrl
// against a priority-rule reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  id_rs_num = '0, id_rt_num = '0;
  logic        id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic [2:0]  idex_dst = '0, exmem_dst = '0, memwb_dst = '0;
  logic        idex_wr = 1'b0, exmem_wr = 1'b0, memwb_wr = 1'b0;
  logic        ex_redirect = 1'b0, imem_stall = 1'b0;
  logic        mem_stall = 1'b0, halt_in = 1'b0;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en;
  logic        halted, mem_timeout;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs_num(id_rs_num), .id_rt_num(id_rt_num),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .idex_dst(idex_dst), .exmem_dst(exmem_dst), .memwb_dst(memwb_dst),
    .idex_wr(idex_wr), .exmem_wr(exmem_wr), .memwb_wr(memwb_wr),
    .ex_redirect(ex_redirect), .imem_stall(imem_stall),
    .mem_stall(mem_stall), .halt_in(halt_in),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
    .halted(halted), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: what the pipeline should do this cycle
  typedef enum {A_RUN, A_FREEZE, A_REDIR, A_RAW, A_IMEM} act_e;

  bit m_halt, m_wait, m_to;
  int m_wcnt, m_stall, m_flush;

  function automatic void m_reset();
    m_halt = 0; m_wait = 0; m_to = 0;
    m_wcnt = 0; m_stall = 0; m_flush = 0;
  endfunction

  function automatic bit m_hazard();
    logic [2:0] dst[3];
    bit         wr[3];
    logic [2:0] src[2];
    bit         use_[2];
    bit         h = 0;
    dst = '{idex_dst, exmem_dst, memwb_dst};
    wr  = '{idex_wr, exmem_wr, memwb_wr};
    src = '{id_rs_num, id_rt_num};
    use_ = '{id_rs_used, id_rt_used};
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 2; k++)
        if (wr[s] && use_[k] && src[k] == dst[s]) h = 1;
    return h;
  endfunction

  function automatic act_e m_action();
    if (!rst) return A_RUN;
    if (m_halt || halt_in || mem_stall) return A_FREEZE;
    if (ex_redirect) return A_REDIR;
    if (m_hazard()) return A_RAW;
    if (imem_stall) return A_IMEM;
    return A_RUN;
  endfunction

  // {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb}
  function automatic logic [7:0] m_vec(input act_e a);
    case (a)
      A_FREEZE: return 8'b0000_0000;
      A_REDIR:  return 8'b1010_1101;
      A_RAW:    return 8'b0000_1101;
      A_IMEM:   return 8'b0011_0101;
      default:  return 8'b1101_0101;
    endcase
  endfunction

  function automatic void m_tick(input act_e a);
    logic [7:0] v;
    if (!rst) begin m_reset(); return; end
    if (m_halt) return;
    v = m_vec(a);
    if (!v[7] && m_stall < 65535) m_stall++;
    if (a == A_REDIR && m_flush < 255) m_flush++;
    if (m_wait && mem_stall) begin
      if (m_wcnt < 63) m_wcnt++;
      if (m_wcnt == 63) m_to = 1;
    end else m_wcnt = 0;
    if (halt_in) begin m_halt = 1; m_wait = 0; end
    else m_wait = mem_stall;
  endfunction

  task automatic cmp();
    chk("ctl", {24'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, exmem_flush, memwb_en}, {24'd0, m_vec(m_action())});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("timeout", {31'd0, mem_timeout}, {31'd0, m_to});
    chk("stall_cycles", {16'd0, stall_cycles}, m_stall);
    chk("flush_count", {24'd0, flush_count}, m_flush);
    chk("en_flush_excl", {29'd0, ifid_en & ifid_flush, idex_en & idex_flush,
                          exmem_en & exmem_flush}, 32'd0);
  endtask

  task automatic step();
    #1;
    cmp();
    m_tick(m_action());
    @(negedge clk);
  endtask

  task automatic zero_in();
    {id_rs_num, id_rt_num, id_rs_used, id_rt_used} = '0;
    {idex_dst, exmem_dst, memwb_dst, idex_wr, exmem_wr, memwb_wr} = '0;
    {ex_redirect, imem_stall, mem_stall, halt_in} = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    zero_in();
    m_reset();
    #1 cmp();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_in(input int mburst);
    id_rs_num = 3'($urandom); id_rt_num = 3'($urandom);
    id_rs_used = 1'($urandom); id_rt_used = 1'($urandom);
    idex_dst = 3'($urandom); exmem_dst = 3'($urandom);
    memwb_dst = 3'($urandom);
    idex_wr = 1'($urandom); exmem_wr = 1'($urandom);
    memwb_wr = 1'($urandom);
    ex_redirect = ($urandom_range(7) == 0);
    imem_stall = ($urandom_range(5) == 0);
    halt_in = ($urandom_range(399) == 0);
    mem_stall = (mburst > 0);
  endtask

  initial begin
    int burst;
    @(negedge clk);
    do_reset();
    step();

    // load-use on rs
    idex_dst = 3'd3; idex_wr = 1'b1; id_rs_num = 3'd3; id_rs_used = 1'b1;
    #1;
    chk("lu_pc_en", {31'd0, pc_en}, 32'd0);
    chk("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
    chk("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    step();
    zero_in();
    #1 chk("lu_stall_cycles", {16'd0, stall_cycles}, 32'd1);
    step();

    // redirect beats a simultaneous hazard
    do_reset();
    exmem_dst = 3'd5; exmem_wr = 1'b1; id_rt_num = 3'd5; id_rt_used = 1'b1;
    ex_redirect = 1'b1;
    #1;
    chk("rr_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    chk("rr_idex_flush", {31'd0, idex_flush}, 32'd1);
    chk("rr_pc_en", {31'd0, pc_en}, 32'd1);
    step();
    zero_in();
    #1 chk("rr_flush_count", {24'd0, flush_count}, 32'd1);
    step();

    // long data-memory stall with a pending redirect
    do_reset();
    mem_stall = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 70; i++) step();
    chk("ms_timeout", {31'd0, mem_timeout}, 32'd1);
    chk("ms_flush_count", {24'd0, flush_count}, 32'd0);
    mem_stall = 1'b0;
    #1 chk("ms_release_pc", {31'd0, pc_en}, 32'd1);
    step();
    ex_redirect = 1'b0;
    step();
    chk("ms_one_redirect", {24'd0, flush_count}, 32'd1);
    step();

    // halt absorbs everything until reset
    do_reset();
    halt_in = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      rand_in(int'($urandom_range(1)));
      step();
    end
    chk("halt_held", {31'd0, halted}, 32'd1);
    do_reset();
    step();
    chk("halt_cleared", {31'd0, halted}, 32'd0);
    chk("post_halt_pc", {31'd0, pc_en}, 32'd1);

    // async reset pulse mid-cycle while waiting on memory
    mem_stall = 1'b1;
    step();
    step();
    #1 rst = 1'b0;
    m_reset();
    #1;
    cmp();
    chk("arst_pc_en", {31'd0, pc_en}, 32'd1);
    rst = 1'b1;
    mem_stall = 1'b0;
    step();
    chk("arst_run", {31'd0, memwb_en}, 32'd1);

    // randomized episodes
    for (int e = 0; e < 8; e++) begin
      do_reset();
      burst = 0;
      for (int c = 0; c < 300; c++) begin
        if (burst == 0 && $urandom_range(19) == 0)
          burst = (e % 2 == 1) ? int'($urandom_range(80, 60))
                               : int'($urandom_range(8, 1));
        rand_in(burst);
        if (burst > 0) burst--;
        step();
      end
    end

    // stall counter saturation under a long fetch stall
    do_reset();
    imem_stall = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    chk("sat_stall_cycles", {16'd0, stall_cycles}, 32'h0000_FFFF);
    chk("sat_ifid_flush", {31'd0, ifid_flush}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
